// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bundle for sync_fifo_flex: requests and write data in,
// read data, occupancy and status out.
interface sync_fifo_flex_if #(
  parameter int DW = 8,
  parameter int DP = 7
);
  localparam int CW = $clog2(DP + 1);

  logic          push;
  logic [DW-1:0] i_data;
  logic          pop;
  logic [DW-1:0] o_data;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  // user side: issues push/pop, observes data and status
  modport master (
    output push, i_data, pop,
    input  o_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  // FIFO side
  modport slave (
    input  push, i_data, pop,
    output o_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with optional first-word-fall-through
// output, programmable almost thresholds, occupancy count, synchronous flush
// and sticky overflow/underflow flags.
module sync_fifo_flex #(
  parameter int DW    = 8,
  parameter int DP    = 7,
  parameter int FWFT  = 0,
  parameter int AF_TH = DP - 1,
  parameter int AE_TH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  sync_fifo_flex_if.slave bus
);
  localparam int CW = $clog2(DP + 1);
  localparam int PW = $clog2(DP);

  localparam logic [CW-1:0] DP_C    = CW'(DP);
  localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_TH);
  localparam logic [PW-1:0] LAST_PT = PW'(DP - 1);

  logic [DW-1:0] mem [DP];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          unf_q;
  logic          full_w;
  logic          empty_w;
  logic          pop_ok;
  logic          push_ok;
  logic          flush;

  // status decodes from the registered count only
  assign full_w  = (count_q == DP_C);
  assign empty_w = (count_q == '0);
  assign flush   = rst || clr;

  // a full FIFO still takes a push when a pop frees a slot in the same cycle
  assign pop_ok  = bus.pop && !empty_w;
  assign push_ok = bus.push && (!full_w || pop_ok);

  // storage write; contents are not reset, flush just discards them
  always_ff @(posedge clk) begin
    if (!flush && push_ok) mem[wr_ptr] <= bus.i_data;
  end

  // pointers wrap by explicit compare so any depth works
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_PT) ? '0 : wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST_PT) ? '0 : rd_ptr + PW'(1);
    end
  end

  // occupancy: simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk) begin
    if (flush) begin
      count_q <= '0;
    end else if (push_ok && !pop_ok) begin
      count_q <= count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_q <= count_q - CW'(1);
    end
  end

  // sticky error flags, cleared only by reset or flush
  always_ff @(posedge clk) begin
    if (flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.push && !push_ok) ovf_q <= 1'b1;
      if (bus.pop && empty_w)   unf_q <= 1'b1;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DW-1:0] dout_q;

      // registered read; reads the old head even when a write lands this edge
      always_ff @(posedge clk) begin
        if (flush) begin
          dout_q <= '0;
        end else if (pop_ok) begin
          dout_q <= mem[rd_ptr];
        end
      end

      assign bus.o_data = dout_q;
    end else begin : g_fwft
      // head word shown directly; forced to zero while empty so reset reads 0
      assign bus.o_data = empty_w ? '0 : mem[rd_ptr];
    end
  endgenerate

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a standard-mode and an FWFT instance, directed
// stimulus, and scoreboard monitors that check read data as it is presented.
module tb_sync_fifo_flex;
  logic clk = 1'b0;
  logic rst;
  logic clr0;
  logic clr1;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic       fire0;

  sync_fifo_flex_if #(.DW(8), .DP(7)) bus0 ();
  sync_fifo_flex_if #(.DW(8), .DP(7)) bus1 ();

  sync_fifo_flex #(.DW(8), .DP(7), .FWFT(0), .AF_TH(6), .AE_TH(1)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr0), .bus(bus0)
  );

  sync_fifo_flex #(.DW(8), .DP(7), .FWFT(1), .AF_TH(6), .AE_TH(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic p, input logic [7:0] d, input logic q);
    bus0.push = p;
    bus0.i_data = d;
    bus0.pop = q;
    tick();
    bus0.push = 1'b0;
    bus0.pop = 1'b0;
  endtask

  task automatic drv1(input logic p, input logic [7:0] d, input logic q);
    bus1.push = p;
    bus1.i_data = d;
    bus1.pop = q;
    tick();
    bus1.push = 1'b0;
    bus1.pop = 1'b0;
  endtask

  // standard mode: an accepted pop makes o_data valid after that edge
  always @(posedge clk) begin
    fire0 <= bus0.pop && !bus0.empty && !rst && !clr0;
  end

  always @(negedge clk) begin
    if (fire0) begin
      if (exp0.size() == 0) begin
        n_total++;
        $display("FAIL sb0_unexpected: got 0x%0h, want no read", bus0.o_data);
      end else begin
        check("sb0_rdata", bus0.o_data, exp0.pop_front());
      end
    end
  end

  // FWFT: head word is visible whenever not empty; accepted pop retires it
  always @(negedge clk) begin
    if (!rst && !bus1.empty) begin
      if (exp1.size() == 0) begin
        n_total++;
        $display("FAIL sb1_unexpected: got 0x%0h, want empty", bus1.o_data);
      end else begin
        check("sb1_head", bus1.o_data, exp1[0]);
      end
    end
  end

  always @(posedge clk) begin
    if (bus1.pop && !bus1.empty && !rst && !clr1 && exp1.size() != 0)
      void'(exp1.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clr0 = 1'b0;
    clr1 = 1'b0;
    bus0.push = 1'b0; bus0.pop = 1'b0; bus0.i_data = '0;
    bus1.push = 1'b0; bus1.pop = 1'b0; bus1.i_data = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_empty", bus0.empty, 1);
    check("rst_aempty", bus0.almost_empty, 1);
    check("rst_full", bus0.full, 0);
    check("rst_afull", bus0.almost_full, 0);
    check("rst_count", bus0.count, 0);
    check("rst_odata", bus0.o_data, 0);
    check("rst_ovf", bus0.overflow, 0);
    check("rst_unf", bus0.underflow, 0);

    for (int i = 1; i <= 7; i++) begin
      drv0(1'b1, 8'(i), 1'b0);
      if (i == 1) check("fill1_aempty", bus0.almost_empty, 1);
      if (i == 2) check("fill2_aempty", bus0.almost_empty, 0);
      if (i == 5) check("fill5_afull", bus0.almost_full, 0);
      if (i == 6) check("fill6_afull", bus0.almost_full, 1);
      if (i == 6) check("fill6_full", bus0.full, 0);
    end
    check("fill7_full", bus0.full, 1);
    check("fill7_count", bus0.count, 7);
    drv0(1'b1, 8'd8, 1'b0);
    check("ovf_count", bus0.count, 7);
    check("ovf_flag", bus0.overflow, 1);
    check("ovf_unf", bus0.underflow, 0);

    for (int i = 1; i <= 7; i++) begin
      exp0.push_back(8'(i));
      drv0(1'b0, 8'h00, 1'b1);
    end
    tick();
    check("drain_empty", bus0.empty, 1);
    check("drain_count", bus0.count, 0);

    for (int i = 1; i <= 4; i++) drv0(1'b1, 8'(i), 1'b0);
    exp0.push_back(8'd1); drv0(1'b0, 8'h00, 1'b1);
    exp0.push_back(8'd2); drv0(1'b0, 8'h00, 1'b1);
    for (int i = 5; i <= 9; i++) drv0(1'b1, 8'(i), 1'b0);
    check("wrap_count", bus0.count, 7);
    check("wrap_full", bus0.full, 1);

    exp0.push_back(8'd3);
    drv0(1'b1, 8'h55, 1'b1);
    check("bothfull_count", bus0.count, 7);
    check("bothfull_odata", bus0.o_data, 3);
    check("bothfull_ovf", bus0.overflow, 1);

    for (int i = 4; i <= 9; i++) begin
      exp0.push_back(8'(i));
      drv0(1'b0, 8'h00, 1'b1);
    end
    exp0.push_back(8'h55);
    drv0(1'b0, 8'h00, 1'b1);
    tick();
    check("wrap_empty", bus0.empty, 1);
    check("wrap_odata_last", bus0.o_data, 8'h55);
    check("wrap_unf", bus0.underflow, 0);

    drv0(1'b1, 8'h11, 1'b1);
    check("bothempty_count", bus0.count, 1);
    check("bothempty_unf", bus0.underflow, 1);
    check("bothempty_odata", bus0.o_data, 8'h55);
    exp0.push_back(8'h11);
    drv0(1'b0, 8'h00, 1'b1);
    tick();

    for (int i = 1; i <= 5; i++) drv0(1'b1, 8'(8'h20 + i), 1'b0);
    check("preflush_count", bus0.count, 5);
    check("preflush_ovf", bus0.overflow, 1);
    clr0 = 1'b1;
    drv0(1'b1, 8'hEE, 1'b1);
    clr0 = 1'b0;
    check("flush_count", bus0.count, 0);
    check("flush_empty", bus0.empty, 1);
    check("flush_ovf", bus0.overflow, 0);
    check("flush_unf", bus0.underflow, 0);
    check("flush_odata", bus0.o_data, 0);
    drv0(1'b1, 8'h42, 1'b0);
    exp0.push_back(8'h42);
    drv0(1'b0, 8'h00, 1'b1);
    tick();
    check("postflush_odata", bus0.o_data, 8'h42);
    check("postflush_empty", bus0.empty, 1);

    check("fwft_rst_empty", bus1.empty, 1);
    exp1.push_back(8'hA5);
    drv1(1'b1, 8'hA5, 1'b0);
    check("fwft_empty", bus1.empty, 0);
    check("fwft_odata", bus1.o_data, 8'hA5);
    tick();
    check("fwft_hold", bus1.o_data, 8'hA5);
    drv1(1'b0, 8'h00, 1'b1);
    check("fwft_pop_empty", bus1.empty, 1);
    exp1.push_back(8'h01);
    drv1(1'b1, 8'h01, 1'b0);
    exp1.push_back(8'h02);
    drv1(1'b1, 8'h02, 1'b0);
    check("fwft_head1", bus1.o_data, 8'h01);
    drv1(1'b0, 8'h00, 1'b1);
    check("fwft_head2", bus1.o_data, 8'h02);
    drv1(1'b0, 8'h00, 1'b1);
    check("fwft_end_empty", bus1.empty, 1);
    tick();

    check("sb0_drained", exp0.size(), 0);
    check("sb1_drained", exp1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO, the successor to our fixed-mode synchronous FIFO. It adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through output mode, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and serves as the general-purpose buffer for datapath blocks.

## Interface
- DW, 8, data width in bits (≥1)
- DP, 7, depth in words (≥2, any integer, not restricted to powers of two)
- FWFT, 0, 0 = standard registered-read mode; 1 = first-word-fall-through mode
- AF_TH, DP-1, almost_full asserts when count ≥ AF_TH (1..DP)
- AE_TH, 1, almost_empty asserts when count ≤ AE_TH (0..DP-1)
- CW (local), $clog2(DP+1), count width

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous flush; same effect as rst on state
- push  in  1  write request
- i_data  in  DW  write data, sampled when a push is accepted
- pop  in  1  read request
- o_data  out  DW  read data
- full  out  1  count == DP
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_TH
- almost_empty  out  1  count ≤ AE_TH
- count  out  CW  current occupancy, 0..DP
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was made while empty

## Operation
- Storage is a DP-entry array with read and write pointers ranging over 0..DP-1. Each pointer wraps to 0 on the increment after DP-1 (explicit compare, not modulo-2^n). count is a registered counter.
- Pop accepted (pop_ok) = pop && !empty.
- Push accepted (push_ok) = push && (!full || pop_ok). A push to a full FIFO is accepted only when a pop is accepted in the same cycle.
- The count update depends on the two accept signals:
  - push_ok only: +1
  - pop_ok only: −1
  - both: unchanged, and both pointers advance
- Overflow is set on push && !push_ok. Underflow is set on pop && empty. Both flags hold until rst or clr.
- A pop on an empty FIFO with a simultaneous push: the push is accepted, the pop is ignored, underflow is set, and count becomes 1.
- Priority order: rst > clr > push/pop.
  - rst or clr zeroes both pointers, count, overflow, underflow, and o_data.
  - push and pop in the same cycle as clr are ignored and do not set the flags.
- All status outputs (full, empty, almost_*) decode combinationally from the registered count only. They do not depend on same-cycle push/pop.
- Standard mode (FWFT=0):
  - o_data is a register loaded with the head word on the edge where pop_ok is true.
  - o_data holds its value otherwise.
  - Read-before-write: on a full-FIFO simultaneous push/pop, o_data receives the old head word, never i_data.
- FWFT mode (FWFT=1):
  - o_data continuously presents the head word (mem[rd_ptr]) while !empty.
  - pop_ok consumes that word.
  - o_data is don't-care while empty and is not checked.

## Timing
- Reset values: o_data=0, full=0, empty=1, almost_full=(AF_TH==0 ? n/a : 0), almost_empty=1, count=0, overflow=0, underflow=0.
- Write latency: a word pushed at edge N is counted at edge N, so empty deasserts after edge N.
- FWFT: o_data shows that word in the cycle after edge N, with no pop required.
- Standard read latency: pop asserted in the cycle before edge N yields valid o_data after edge N (1 cycle).
- Throughput: one push and one pop per cycle, sustained, at any occupancy.
- rst or clr asserted mid-operation takes effect at the next edge. Stored data is discarded.

## Test plan
All scenarios use DP=7, DW=8, AF_TH=6, AE_TH=1 unless noted.
- Reset:
  - Stimulus: hold rst for 2 cycles, then release.
  - Required: empty=1, almost_empty=1, full=0, almost_full=0, count=0, o_data=0, overflow=0, underflow=0.
- Fill and overflow:
  - Stimulus: push 1..7 back-to-back, then push 8.
  - Required: almost_empty drops after the 2nd push; almost_full rises after the 6th; full=1 and count=7 after the 7th. The push of 8 leaves count=7 and sets overflow=1.
  - Then pop 7 times: o_data sequence is 1..7, each value valid one cycle after its pop; empty=1 at the end.
- Wrap-around (non-power-of-two depth):
  - Stimulus: push 1..4, pop 2, push 5..9 (count reaches 7, write pointer wraps), then pop 7.
  - Required: o_data sequence 3,4,5,6,7,8,9.
- Simultaneous push/pop at the boundaries:
  - Full case: on a full FIFO with head=3, push 0x55 and pop in the same cycle. Required: count stays 7, o_data=3, overflow unchanged, and 0x55 is popped last.
  - Empty case: on an empty FIFO, push 0x11 and pop in the same cycle. Required: count=1, underflow=1, o_data unchanged.
- FWFT=1:
  - Stimulus: push 0xA5.
  - Required: one cycle later empty=0 and o_data=0xA5 with no pop. After a pop, empty=1.
  - Then push 0x01 and 0x02 and pop twice. Required: o_data shows 0x01, then 0x02.
- Flush mid-operation:
  - Stimulus: with count=5 and overflow=1, assert clr together with push=1 and pop=1 for one cycle.
  - Required: next cycle count=0, empty=1, overflow=0, underflow=0, o_data=0.
  - A subsequent push of 0x42 followed by a pop returns 0x42.
